// File: rtl/ssd_scan_bcd.sv
// Binary-to-BCD converter (sequential double dabble) with atomic display latch
// and time-multiplexed seven-segment digit scanning.
module ssd_scan_bcd #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned VAL_W      = 14,
    parameter int unsigned SCAN_DIV_W = 15,
    parameter int unsigned BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VAL_W-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] ssd_ctl,
    output logic [3:0]            digit
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(VAL_W + 1);
    localparam int unsigned SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    state_t            state, state_next;
    logic [BCD_W-1:0]  bcd, bcd_next, bcd_adj;
    logic [BCD_W-1:0]  disp, disp_next;
    logic [VAL_W-1:0]  bin, bin_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              ovf, ovf_next;
    logic              busy_next, overflow_next;
    logic [SCAN_DIV_W-1:0] scan_cnt;
    logic [SEL_W-1:0]  sel;
    logic              upper_nz;

    // Per-nibble add-3 correction, no carry between nibbles
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bcd      <= '0;
            bin      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            disp     <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            bcd      <= bcd_next;
            bin      <= bin_next;
            cnt      <= cnt_next;
            ovf      <= ovf_next;
            disp     <= disp_next;
            busy     <= busy_next;
            overflow <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state;
        bcd_next      = bcd;
        bin_next      = bin;
        cnt_next      = cnt;
        ovf_next      = ovf;
        disp_next     = disp;
        busy_next     = busy;
        overflow_next = overflow;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    bin_next   = value;
                    bcd_next   = '0;
                    ovf_next   = 1'b0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A bit leaving the top nibble means the value needs more digits
                bcd_next = {bcd_adj[BCD_W-2:0], bin[VAL_W-1]};
                bin_next = bin << 1;
                ovf_next = ovf | bcd_adj[BCD_W-1];
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(VAL_W - 1)) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_next     = ovf ? {NUM_DIGITS{4'h9}} : bcd;
                overflow_next = ovf;
                busy_next     = 1'b0;
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Free-running dwell counter; digit select advances on wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            sel      <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_DIV_W'(1);
            if (scan_cnt == {SCAN_DIV_W{1'b1}}) begin
                sel <= (sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel + SEL_W'(1);
            end
        end
    end

    // Walk from the top digit down so upper_nz covers this nibble and all above
    always_comb begin
        ssd_ctl  = '1;
        digit    = 4'h0;
        upper_nz = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            upper_nz = upper_nz | (disp[4*i +: 4] != 4'h0);
            if (sel == SEL_W'(i)) begin
                ssd_ctl[i] = 1'b0;
                digit      = disp[4*i +: 4];
                if ((BLANK_LZ != 0) && (i != 0) && !upper_nz) begin
                    digit = 4'hF;
                end
            end
        end
    end

endmodule
